// File: rtl/ram_port_arbiter_pkg.sv
// Shared definitions for the basic_ram port arbiter: FSM states and arbitration modes.
package ram_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } arb_state_t;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    // Boot loader always moves full words.
    localparam logic [1:0] BOOT_SIZE = 2'b11;

endpackage

// File: rtl/ram_port_arbiter_arb_select.sv
// arb_select: combinational N-way priority picker. The scan starts at 'start'
// and wraps, so start=0 gives fixed priority and a rotating start gives round-robin.
module arb_select #(
    parameter int N     = 2,
    parameter int PTR_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] start,
    output logic             any,
    output logic [PTR_W-1:0] idx,
    output logic [N-1:0]     onehot
);

    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] cand;

    // Walk the requests circularly from start; the first one found wins.
    always_comb begin
        // NOTE: every output gets a default first, so no path through the loop infers a latch.
        any    = 1'b0;
        idx    = '0;
        onehot = '0;
        sum    = '0;
        cand   = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, start} + (PTR_W + 1)'(k);
            if (sum >= (PTR_W + 1)'(N)) begin
                sum = sum - (PTR_W + 1)'(N);
            end
            cand = sum[PTR_W-1:0];
            if (!any && req[cand]) begin
                any          = 1'b1;
                idx          = cand;
                onehot[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one basic_ram port among N masters. The winning request
// is registered and held on the RAM side until mem_done (or a timeout), then a
// one-cycle ready (and error on timeout) is returned to the winner.
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int N_MASTERS   = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int RAM_ADDR_W  = 14,
    parameter int ARB_MODE    = 0,
    parameter int BOOT_MASTER = 0,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          boot_lock,
    input  logic [N_MASTERS*ADDR_W-1:0]   m_addr,
    input  logic [N_MASTERS*DATA_W-1:0]   m_d_in,
    input  logic [2*N_MASTERS-1:0]        m_size,
    input  logic [N_MASTERS-1:0]          m_cs,
    input  logic [N_MASTERS-1:0]          m_we,
    input  logic [N_MASTERS-1:0]          m_oe,
    output logic [DATA_W-1:0]             m_d_out,
    output logic [N_MASTERS-1:0]          m_ready,
    output logic [N_MASTERS-1:0]          m_err,
    output logic [N_MASTERS-1:0]          grant,
    output logic [RAM_ADDR_W-1:0]         ram_addr,
    output logic [DATA_W-1:0]             ram_d_in,
    output logic                          ram_cs,
    output logic                          ram_we,
    output logic                          ram_oe,
    output logic [1:0]                    ram_size,
    input  logic [DATA_W-1:0]             ram_d_out,
    input  logic                          ram_ready
);

    localparam int PTR_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYC);

    localparam logic [PTR_W-1:0]     BOOT_IDX  = PTR_W'(BOOT_MASTER);
    localparam logic [PTR_W-1:0]     LAST_IDX  = PTR_W'(N_MASTERS - 1);
    localparam logic [N_MASTERS-1:0] BOOT_MASK = N_MASTERS'(1) << BOOT_MASTER;
    localparam logic [CNT_W-1:0]     TO_LAST   = CNT_W'(TIMEOUT_CYC - 1);

    arb_state_t             state;
    logic [PTR_W-1:0]       rr_ptr;
    logic [PTR_W-1:0]       own_idx;
    logic [CNT_W-1:0]       to_cnt;

    logic [N_MASTERS-1:0]   eligible;
    logic [PTR_W-1:0]       sel_start;
    logic                   win_any;
    logic [PTR_W-1:0]       win_idx;
    logic [N_MASTERS-1:0]   win_onehot;

    logic [RAM_ADDR_W-1:0]  addr_arr [N_MASTERS];
    logic [DATA_W-1:0]      din_arr  [N_MASTERS];
    logic [1:0]             size_arr [N_MASTERS];

    for (genvar i = 0; i < N_MASTERS; i++) begin : g_unpack
        assign addr_arr[i] = m_addr[i*ADDR_W +: RAM_ADDR_W];
        assign din_arr[i]  = m_d_in[i*DATA_W +: DATA_W];
        assign size_arr[i] = m_size[i*2 +: 2];
    end

    assign eligible  = m_cs & (boot_lock ? BOOT_MASK : '1);
    assign sel_start = (ARB_MODE == ARB_RR) ? rr_ptr : '0;

    arb_select #(
        .N     (N_MASTERS),
        .PTR_W (PTR_W)
    ) u_select (
        .req    (eligible),
        .start  (sel_start),
        .any    (win_any),
        .idx    (win_idx),
        .onehot (win_onehot)
    );

    // Transaction FSM: grant and latch in IDLE, hold the RAM side in ACCESS, report in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            rr_ptr   <= '0;
            own_idx  <= '0;
            to_cnt   <= '0;
            grant    <= '0;
            m_ready  <= '0;
            m_err    <= '0;
            m_d_out  <= '0;
            ram_cs   <= 1'b0;
            ram_we   <= 1'b0;
            ram_oe   <= 1'b0;
            ram_addr <= '0;
            ram_d_in <= '0;
            ram_size <= '0;
        end else begin
            // NOTE: non-blocking assignments, so every branch below sees pre-edge register values.
            m_ready <= '0;
            m_err   <= '0;
            case (state)
                ST_IDLE: begin
                    if (win_any) begin
                        own_idx  <= win_idx;
                        grant    <= win_onehot;
                        ram_cs   <= 1'b1;
                        ram_we   <= m_we[win_idx];
                        ram_oe   <= m_oe[win_idx];
                        ram_addr <= addr_arr[win_idx];
                        ram_d_in <= din_arr[win_idx];
                        ram_size <= (boot_lock && (win_idx == BOOT_IDX)) ? BOOT_SIZE
                                                                         : size_arr[win_idx];
                        to_cnt   <= '0;
                        state    <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (ram_ready) begin
                        m_d_out <= ram_d_out;
                        m_ready <= grant;
                        ram_cs  <= 1'b0;
                        ram_we  <= 1'b0;
                        ram_oe  <= 1'b0;
                        state   <= ST_DONE;
                    end else if (to_cnt == TO_LAST) begin
                        m_d_out <= '0;
                        m_ready <= grant;
                        m_err   <= grant;
                        ram_cs  <= 1'b0;
                        ram_we  <= 1'b0;
                        ram_oe  <= 1'b0;
                        state   <= ST_DONE;
                    end else begin
                        to_cnt <= to_cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    grant  <= '0;
                    to_cnt <= '0;
                    rr_ptr <= (own_idx == LAST_IDX) ? '0 : own_idx + PTR_W'(1);
                    state  <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Testbench for ram_port_arbiter: 3 masters, round-robin, boot master 0, timeout 8.
// Stimulus issues requests and pushes predicted transactions; a monitor pops and
// compares as the DUT drives the RAM side and returns ready.
module tb_ram_port_arbiter;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int RW = 14;
    localparam int TO = 8;
    localparam logic [N-1:0] BOOT_MASK = 3'b001;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              boot_lock = 1'b0;
    logic [N*AW-1:0]   m_addr = '0;
    logic [N*DW-1:0]   m_d_in = '0;
    logic [2*N-1:0]    m_size = '0;
    logic [N-1:0]      m_cs = '0;
    logic [N-1:0]      m_we = '0;
    logic [N-1:0]      m_oe = '0;
    logic [DW-1:0]     m_d_out;
    logic [N-1:0]      m_ready;
    logic [N-1:0]      m_err;
    logic [N-1:0]      grant;
    logic [RW-1:0]     ram_addr;
    logic [DW-1:0]     ram_d_in;
    logic              ram_cs;
    logic              ram_we;
    logic              ram_oe;
    logic [1:0]        ram_size;
    logic [DW-1:0]     ram_d_out = '0;
    logic              ram_ready = 1'b0;
    logic              ram_stall = 1'b0;

    ram_port_arbiter #(
        .N_MASTERS   (N),
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .RAM_ADDR_W  (RW),
        .ARB_MODE    (1),
        .BOOT_MASTER (0),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .boot_lock (boot_lock),
        .m_addr    (m_addr),
        .m_d_in    (m_d_in),
        .m_size    (m_size),
        .m_cs      (m_cs),
        .m_we      (m_we),
        .m_oe      (m_oe),
        .m_d_out   (m_d_out),
        .m_ready   (m_ready),
        .m_err     (m_err),
        .grant     (grant),
        .ram_addr  (ram_addr),
        .ram_d_in  (ram_d_in),
        .ram_cs    (ram_cs),
        .ram_we    (ram_we),
        .ram_oe    (ram_oe),
        .ram_size  (ram_size),
        .ram_d_out (ram_d_out),
        .ram_ready (ram_ready)
    );

    initial forever #5 clk = ~clk;

    logic [91:0] all_outs;
    assign all_outs = {m_d_out, m_ready, m_err, grant, ram_addr, ram_d_in,
                       ram_cs, ram_we, ram_oe, ram_size};

    typedef struct {
        logic        we;
        logic        oe;
        logic [31:0] addr;
        logic [31:0] d_in;
        logic [1:0]  size;
    } op_t;

    typedef struct {
        int          master;
        logic        we;
        logic        oe;
        logic [13:0] addr;
        logic [31:0] d_in;
        logic [1:0]  size;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    op_t         ops[N];
    logic [31:0] ref_mem[int];
    logic [31:0] ram_mem[int];
    int          ref_ptr = 0;
    int          n_vec = 0;
    int          n_bad = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: one transaction's visible effect, from the arbiter's rules.
    function automatic exp_t model_txn(input int m, input op_t op, input bit boot, input bit timeout);
        exp_t e;
        int   key;
        e.master = m;
        e.we     = op.we;
        e.oe     = op.oe;
        e.addr   = op.addr[13:0];
        e.d_in   = op.d_in;
        e.size   = (boot && m == 0) ? 2'b11 : op.size;
        e.err    = timeout;
        e.data   = 32'h0;
        key      = int'(e.addr);
        if (!timeout) begin
            if (op.we) ref_mem[key] = op.d_in;
            else if (op.oe) e.data = ref_mem.exists(key) ? ref_mem[key] : 32'h0;
        end
        return e;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        int  kind;
        kind   = $urandom_range(0, 7);
        o.we   = (kind < 3);
        o.oe   = (kind >= 3 && kind < 7);
        o.addr = $urandom();
        o.addr[13:0] = 14'($urandom_range(0, 15));
        o.d_in = $urandom();
        o.size = 2'($urandom_range(0, 3));
        return o;
    endfunction

    task automatic drive_master(input int i);
        m_addr[i*AW +: AW] = ops[i].addr;
        m_d_in[i*DW +: DW] = ops[i].d_in;
        m_size[i*2 +: 2]   = ops[i].size;
        m_we[i]            = ops[i].we;
        m_oe[i]            = ops[i].oe;
        m_cs[i]            = 1'b1;
    endtask

    task automatic wait_ready(input int m, input string name);
        int cyc;
        cyc = 0;
        while (!m_ready[m] && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (!m_ready[m]) check(name, m_ready[m], 1'b1);
        m_cs[m] = 1'b0;
    endtask

    // All masters in mask request together; service order is circular from the rr pointer.
    task automatic run_round(input logic [N-1:0] mask, input bit timeout);
        logic [N-1:0] pend;
        int start, last, cyc;
        start = ref_ptr;
        last  = -1;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (start + k) % N;
            if (mask[idx]) begin
                exp_q.push_back(model_txn(idx, ops[idx], 1'b0, timeout));
                last = idx;
            end
        end
        if (last >= 0) ref_ptr = (last + 1) % N;
        for (int i = 0; i < N; i++) if (mask[i]) drive_master(i);
        pend = mask;
        cyc  = 0;
        while (pend != 0 && cyc < 200) begin
            @(posedge clk); #1;
            pend = pend & ~m_ready;
            m_cs = m_cs & ~m_ready;
            cyc++;
        end
        if (pend != 0) begin
            check("round_budget", pend, 0);
            m_cs = '0;
            exp_q.delete();
        end
    endtask

    task automatic random_round();
        logic [N-1:0] mask;
        bit           to;
        to = ($urandom_range(0, 7) == 0);
        if (to) mask = 3'b001 << $urandom_range(0, N - 1);
        else    mask = 3'($urandom_range(1, 7));
        for (int i = 0; i < N; i++) begin
            ops[i] = rand_op();
            if (to) begin
                ops[i].we = 1'b0;
                ops[i].oe = 1'b1;
            end
        end
        ram_stall = to;
        run_round(mask, to);
        ram_stall = 1'b0;
    endtask

    // Behavioural basic_ram: mem_done after 1..4 cycles of cs, never while stalled.
    initial begin : ram_model
        int wait_cnt;
        int key;
        wait_cnt = -1;
        forever begin
            @(posedge clk); #1;
            if (ram_ready) begin
                ram_ready = 1'b0;
                wait_cnt  = -1;
            end else if (!ram_cs) begin
                wait_cnt = -1;
            end else if (!ram_stall) begin
                if (wait_cnt < 0) wait_cnt = $urandom_range(0, 3);
                if (wait_cnt == 0) begin
                    key       = int'(ram_addr);
                    ram_ready = 1'b1;
                    ram_d_out = 32'h0;
                    if (ram_we) ram_mem[key] = ram_d_in;
                    else if (ram_oe) ram_d_out = ram_mem.exists(key) ? ram_mem[key] : 32'h0;
                    wait_cnt = -1;
                end else begin
                    wait_cnt--;
                end
            end
        end
    end

    // Monitor: pops an expectation when an access starts, checks it through completion.
    initial begin : monitor
        exp_t         cur;
        bit           in_txn;
        int           acc;
        logic [N-1:0] oh;
        in_txn = 1'b0;
        acc    = 0;
        oh     = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_txn = 1'b0;
                acc    = 0;
            end else begin
                if (boot_lock) check("boot_lock_grant", grant & ~BOOT_MASK, 0);
                if (ram_cs) begin
                    if (!in_txn) begin
                        if (exp_q.size() == 0) begin
                            check("unexpected_access", ram_cs, 1'b0);
                        end else begin
                            cur    = exp_q.pop_front();
                            oh     = 3'b001 << cur.master;
                            in_txn = 1'b1;
                            acc    = 0;
                        end
                    end
                    if (in_txn) begin
                        acc++;
                        check("ram_side", {grant, ram_we, ram_oe, ram_addr, ram_d_in, ram_size},
                              {oh, cur.we, cur.oe, cur.addr, cur.d_in, cur.size});
                    end
                end
                if (m_ready != 0 || m_err != 0) begin
                    if (!in_txn) begin
                        check("unexpected_ready", {m_ready, m_err}, 0);
                    end else begin
                        check("m_ready", m_ready, oh);
                        check("m_err", m_err, cur.err ? oh : 3'b000);
                        check("m_d_out", m_d_out, cur.data);
                        check("grant_at_ready", grant, oh);
                        check("ram_idle_in_done", {ram_cs, ram_we, ram_oe}, 0);
                        if (cur.err) check("timeout_cycles", acc, TO);
                        in_txn = 1'b0;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_bad);
        $fatal(1);
    end

    initial begin : main
        int cyc;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", all_outs, 0);
        rst_n = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            check("idle_after_reset", all_outs, 0);
        end

        // Boot phase: only master 0 may be granted, and its size is forced to a full word.
        boot_lock = 1'b1;
        ops[0] = '{we: 1'b1, oe: 1'b0, addr: 32'h10, d_in: 32'hDEADBEEF, size: 2'b00};
        ops[1] = '{we: 1'b0, oe: 1'b1, addr: 32'h10, d_in: 32'h12345678, size: 2'b10};
        exp_q.push_back(model_txn(0, ops[0], 1'b1, 1'b0));
        ref_ptr = 1;
        drive_master(0);
        drive_master(1);
        wait_ready(0, "boot_m0_done");
        repeat (6) begin
            @(posedge clk); #1;
            check("boot_m1_held", grant, 0);
        end
        boot_lock = 1'b0;
        exp_q.push_back(model_txn(1, ops[1], 1'b0, 1'b0));
        ref_ptr = 2;
        wait_ready(1, "boot_m1_done");

        repeat (40) random_round();

        // Asynchronous reset in the middle of a stalled access.
        ram_stall = 1'b1;
        ops[2]    = rand_op();
        ops[2].we = 1'b0;
        ops[2].oe = 1'b1;
        exp_q.push_back(model_txn(2, ops[2], 1'b0, 1'b1));
        drive_master(2);
        cyc = 0;
        while (!ram_cs && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("reset_test_access", ram_cs, 1'b1);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset_drop", {ram_cs, grant, m_ready}, 0);
        m_cs = '0;
        exp_q.delete();
        ref_ptr   = 0;
        ram_stall = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // All masters held: grants 001, 010, 100, then 001 again.
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < N; i++) ops[i] = rand_op();
            run_round(3'b111, 1'b0);
        end

        repeat (5) @(posedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
